// File: rtl/hwpe_switch_ctrl_if.sv
// Handshake and status bundle between the HWPE switch controller and its
// surroundings: enable/select requests, busy flags, the selected channel's
// TCDM handshake, and the gating/select/stall outputs of the controller.
interface hwpe_switch_ctrl_if #(
    parameter int N_HWPES         = 4,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int SW = (N_HWPES == 1) ? 1 : $clog2(N_HWPES);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic               hwpe_en_i;
    logic [SW-1:0]      hwpe_sel_i;
    logic [N_HWPES-1:0] busy_i;
    logic               tcdm_req_i;
    logic               tcdm_gnt_i;
    logic               tcdm_r_valid_i;
    logic               cfg_req_i;
    logic [N_HWPES-1:0] hwpe_clk_en_o;
    logic [SW-1:0]      sel_o;
    logic               req_block_o;
    logic               cfg_stall_o;
    logic               switch_done_o;
    logic [CW-1:0]      outstanding_o;
    logic [2:0]         err_o;

    // Environment side: issues requests, observes controller status.
    modport master (
        output hwpe_en_i, hwpe_sel_i, busy_i, tcdm_req_i, tcdm_gnt_i,
               tcdm_r_valid_i, cfg_req_i,
        input  hwpe_clk_en_o, sel_o, req_block_o, cfg_stall_o,
               switch_done_o, outstanding_o, err_o
    );

    // Controller side.
    modport slave (
        input  hwpe_en_i, hwpe_sel_i, busy_i, tcdm_req_i, tcdm_gnt_i,
               tcdm_r_valid_i, cfg_req_i,
        output hwpe_clk_en_o, sel_o, req_block_o, cfg_stall_o,
               switch_done_o, outstanding_o, err_o
    );
endinterface

// File: rtl/hwpe_switch_ctrl.sv
// HWPE switch controller: picks which HWPE behind the static HCI mux owns the
// TCDM and config buses, gates the clocks of all others, and only moves the
// select once the current owner is idle and its TCDM traffic has drained.
module hwpe_switch_ctrl #(
    parameter int N_HWPES         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SWITCH_GAP      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    hwpe_switch_ctrl_if.slave bus
);
    localparam int SW = (N_HWPES == 1) ? 1 : $clog2(N_HWPES);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [SW:0]   N_LIM    = (SW + 1)'(N_HWPES);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [3:0]    GAP_INIT = 4'(SWITCH_GAP);

    typedef enum logic [1:0] {OFF, GAP, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [3:0]    gap_q, gap_d;
    logic          done_q, done_d;
    logic          err_sel_q, err_sel_d;
    logic [CW-1:0] cnt_q;
    logic          err_ovf_q, err_unf_q;

    logic sel_legal;
    logic change_req;
    logic inc, dec;
    logic [N_HWPES-1:0] clk_en;

    assign sel_legal  = ({1'b0, bus.hwpe_sel_i} < N_LIM);
    // A legal different index or a disable both ask to leave RUN; an illegal
    // index while enabled is flagged but otherwise ignored.
    assign change_req = !bus.hwpe_en_i || (sel_legal && (bus.hwpe_sel_i != sel_q));
    assign inc        = bus.tcdm_req_i & bus.tcdm_gnt_i;
    assign dec        = bus.tcdm_r_valid_i;

    // State, selection, gap timer and select-error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF;
            sel_q     <= '0;
            gap_q     <= '0;
            done_q    <= 1'b0;
            err_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            err_sel_q <= err_sel_d;
        end
    end

    // Next-state logic; the select is only reloaded on entry to GAP.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        err_sel_d = err_sel_q;
        case (state_q)
            OFF: begin
                if (bus.hwpe_en_i) begin
                    if (sel_legal) begin
                        sel_d   = bus.hwpe_sel_i;
                        gap_d   = GAP_INIT;
                        state_d = GAP;
                    end else begin
                        err_sel_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            RUN: begin
                if (bus.hwpe_en_i && !sel_legal)
                    err_sel_d = 1'b1;
                if (change_req && !bus.busy_i[sel_q] && !bus.cfg_req_i)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    if (!bus.hwpe_en_i) begin
                        state_d = OFF;
                    end else if (sel_legal) begin
                        sel_d   = bus.hwpe_sel_i;
                        gap_d   = GAP_INIT;
                        state_d = GAP;
                    end else begin
                        err_sel_d = 1'b1;
                        state_d   = OFF;
                    end
                end
            end
            default: state_d = OFF;
        endcase
    end

    // In-flight TCDM transaction counter with saturating/flooring error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else if (inc && !dec) begin
            if (cnt_q == MAX_CNT) err_ovf_q <= 1'b1;
            else                  cnt_q     <= cnt_q + CW'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) err_unf_q <= 1'b1;
            else             cnt_q     <= cnt_q - CW'(1);
        end
    end

    // Clock enable follows the owner through RUN and DRAIN so it can retire
    // its outstanding responses.
    always_comb begin
        clk_en = '0;
        if (state_q == RUN || state_q == DRAIN) begin
            for (int i = 0; i < N_HWPES; i++)
                if (int'(sel_q) == i) clk_en[i] = 1'b1;
        end
    end

    assign bus.hwpe_clk_en_o = clk_en;
    assign bus.sel_o         = (N_HWPES == 1) ? '0 : sel_q;
    assign bus.req_block_o   = (state_q != RUN) || (cnt_q == MAX_CNT);
    assign bus.cfg_stall_o   = (state_q != RUN);
    assign bus.switch_done_o = done_q;
    assign bus.outstanding_o = cnt_q;
    assign bus.err_o         = {err_sel_q, err_unf_q, err_ovf_q};
endmodule

// File: tb/tb_hwpe_switch_ctrl.sv
// Bench for hwpe_switch_ctrl: two instances (4 and 3 HWPEs) share one stimulus
// stream and are compared every cycle against a behavioural model, with
// directed scenarios followed by randomized traffic.
module tb_hwpe_switch_ctrl;
    localparam int MAXO = 8;
    localparam int GAPC = 2;

    typedef enum int {M_OFF, M_GAP, M_RUN, M_DRAIN} mode_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] busy = 4'd0;
    logic       req = 1'b0, gnt = 1'b0, rv = 1'b0, cfg = 1'b0;

    int checks = 0;
    int errors = 0;

    mode_t    m_mode[2];
    int       m_sel[2];
    int       m_gap[2];
    int       m_cnt[2];
    bit [2:0] m_err[2];
    bit       m_done[2];

    always #5 clk = ~clk;

    hwpe_switch_ctrl_if #(.N_HWPES(4), .MAX_OUTSTANDING(MAXO)) if0 ();
    hwpe_switch_ctrl_if #(.N_HWPES(3), .MAX_OUTSTANDING(MAXO)) if1 ();

    assign if0.hwpe_en_i = en;      assign if1.hwpe_en_i = en;
    assign if0.hwpe_sel_i = sel;    assign if1.hwpe_sel_i = sel;
    assign if0.busy_i = busy;       assign if1.busy_i = busy[2:0];
    assign if0.tcdm_req_i = req;    assign if1.tcdm_req_i = req;
    assign if0.tcdm_gnt_i = gnt;    assign if1.tcdm_gnt_i = gnt;
    assign if0.tcdm_r_valid_i = rv; assign if1.tcdm_r_valid_i = rv;
    assign if0.cfg_req_i = cfg;     assign if1.cfg_req_i = cfg;

    hwpe_switch_ctrl #(.N_HWPES(4), .MAX_OUTSTANDING(MAXO), .SWITCH_GAP(GAPC)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    hwpe_switch_ctrl #(.N_HWPES(3), .MAX_OUTSTANDING(MAXO), .SWITCH_GAP(GAPC)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_OFF; m_sel[k] = 0; m_gap[k] = 0;
            m_cnt[k] = 0; m_err[k] = 3'b000; m_done[k] = 1'b0;
        end
    endtask

    // One clock of the behavioural model, using the inputs the DUTs sampled.
    task automatic model_step();
        int  n, cnt_old;
        bit  legal, want;
        for (int k = 0; k < 2; k++) begin
            n       = (k == 0) ? 4 : 3;
            legal   = (int'(sel) < n);
            cnt_old = m_cnt[k];
            if (req && gnt && !rv) begin
                if (m_cnt[k] == MAXO) m_err[k][0] = 1'b1; else m_cnt[k]++;
            end else if (rv && !(req && gnt)) begin
                if (m_cnt[k] == 0) m_err[k][1] = 1'b1; else m_cnt[k]--;
            end
            m_done[k] = 1'b0;
            case (m_mode[k])
                M_OFF: if (en) begin
                    if (legal) begin
                        m_sel[k] = int'(sel); m_gap[k] = GAPC; m_mode[k] = M_GAP;
                    end else m_err[k][2] = 1'b1;
                end
                M_GAP: begin
                    m_gap[k]--;
                    if (m_gap[k] == 0) begin m_mode[k] = M_RUN; m_done[k] = 1'b1; end
                end
                M_RUN: begin
                    if (en && !legal) m_err[k][2] = 1'b1;
                    want = !en || (legal && int'(sel) != m_sel[k]);
                    if (want && !busy[m_sel[k]] && !cfg) m_mode[k] = M_DRAIN;
                end
                M_DRAIN: if (cnt_old == 0) begin
                    if (!en) m_mode[k] = M_OFF;
                    else if (legal) begin
                        m_sel[k] = int'(sel); m_gap[k] = GAPC; m_mode[k] = M_GAP;
                    end else begin
                        m_err[k][2] = 1'b1; m_mode[k] = M_OFF;
                    end
                end
                default: m_mode[k] = M_OFF;
            endcase
        end
    endtask

    task automatic check_all();
        logic [3:0] ce; logic [1:0] s; logic rb, cs, sd; logic [3:0] oc; logic [2:0] er;
        int exp_ce;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                ce = if0.hwpe_clk_en_o; s = if0.sel_o; rb = if0.req_block_o;
                cs = if0.cfg_stall_o; sd = if0.switch_done_o; oc = if0.outstanding_o; er = if0.err_o;
            end else begin
                ce = {1'b0, if1.hwpe_clk_en_o}; s = if1.sel_o; rb = if1.req_block_o;
                cs = if1.cfg_stall_o; sd = if1.switch_done_o; oc = if1.outstanding_o; er = if1.err_o;
            end
            exp_ce = (m_mode[k] == M_RUN || m_mode[k] == M_DRAIN) ? (1 << m_sel[k]) : 0;
            check($sformatf("d%0d_clk_en", k), ce, exp_ce);
            check($sformatf("d%0d_sel", k), s, m_sel[k]);
            check($sformatf("d%0d_req_block", k), rb, (m_mode[k] != M_RUN) || (m_cnt[k] == MAXO));
            check($sformatf("d%0d_cfg_stall", k), cs, m_mode[k] != M_RUN);
            check($sformatf("d%0d_switch_done", k), sd, m_done[k]);
            check($sformatf("d%0d_outstanding", k), oc, m_cnt[k]);
            check($sformatf("d%0d_err", k), er, m_err[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #3 check_all();
        check("rst_clk_en", if0.hwpe_clk_en_o, 4'b0000);
        check("rst_req_block", if0.req_block_o, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Select HWPE 2 from OFF: two GAP cycles, then RUN.
        en = 1'b1; sel = 2'd2;
        cycle();
        check("gap_cfg_stall", if0.cfg_stall_o, 1'b1);
        check("gap_clk_en", if0.hwpe_clk_en_o, 4'b0000);
        cycle();
        cycle();
        check("run2_clk_en", if0.hwpe_clk_en_o, 4'b0100);
        check("run2_done", if0.switch_done_o, 1'b1);
        check("run2_cfg_stall", if0.cfg_stall_o, 1'b0);
        check("run2_clk_en_n3", if1.hwpe_clk_en_o, 3'b100);
        cycle();
        check("run2_done_pulse", if0.switch_done_o, 1'b0);

        // Three grants in flight, then switch to HWPE 1 through DRAIN.
        req = 1'b1; gnt = 1'b1;
        repeat (3) cycle();
        req = 1'b0; gnt = 1'b0; sel = 2'd1;
        cycle();
        check("drain_req_block", if0.req_block_o, 1'b1);
        check("drain_clk_en", if0.hwpe_clk_en_o, 4'b0100);
        check("drain_outstanding", if0.outstanding_o, 4'd3);
        rv = 1'b1;
        repeat (3) cycle();
        rv = 1'b0;
        cycle();
        check("gap1_sel", if0.sel_o, 2'd1);
        check("gap1_clk_en", if0.hwpe_clk_en_o, 4'b0000);
        cycle();
        cycle();
        check("run1_clk_en", if0.hwpe_clk_en_o, 4'b0010);

        // A busy owner defers the switch indefinitely.
        busy = 4'b0010; sel = 2'd0;
        repeat (100) cycle();
        check("busy_hold_cfg_stall", if0.cfg_stall_o, 1'b0);
        check("busy_hold_clk_en", if0.hwpe_clk_en_o, 4'b0010);
        busy = 4'b0000;
        cycle();
        check("busy_drop_drain", if0.cfg_stall_o, 1'b1);
        cycle();
        cycle();
        cycle();
        check("run0_clk_en", if0.hwpe_clk_en_o, 4'b0001);

        // Counter saturation and underflow.
        req = 1'b1; gnt = 1'b1;
        repeat (8) cycle();
        check("full_req_block", if0.req_block_o, 1'b1);
        check("full_outstanding", if0.outstanding_o, 4'd8);
        cycle();
        check("ovf_outstanding", if0.outstanding_o, 4'd8);
        check("ovf_err", if0.err_o, 3'b001);
        req = 1'b0; gnt = 1'b0; rv = 1'b1;
        repeat (9) cycle();
        rv = 1'b0;
        check("unf_err", if0.err_o, 3'b011);
        check("unf_outstanding", if0.outstanding_o, 4'd0);

        // Disable while a config request is pending: deferred, then OFF.
        cfg = 1'b1; en = 1'b0;
        repeat (10) cycle();
        check("cfg_hold_cfg_stall", if0.cfg_stall_o, 1'b0);
        cfg = 1'b0;
        cycle();
        check("cfg_drain_clk_en", if0.hwpe_clk_en_o, 4'b0001);
        cycle();
        check("off_clk_en", if0.hwpe_clk_en_o, 4'b0000);
        check("off_cfg_stall", if0.cfg_stall_o, 1'b1);

        // Illegal index on the 3-HWPE instance.
        do_reset();
        en = 1'b1; sel = 2'd3;
        cycle();
        check("ill_err_n3", if1.err_o, 3'b100);
        check("ill_cfg_stall_n3", if1.cfg_stall_o, 1'b1);
        repeat (4) cycle();
        check("ill_stay_off_n3", if1.hwpe_clk_en_o, 3'b000);
        check("ill_legal_n4", if0.hwpe_clk_en_o, 4'b1000);

        // Reset in DRAIN with transactions in flight, then resume from OFF.
        req = 1'b1; gnt = 1'b1;
        repeat (2) cycle();
        req = 1'b0; gnt = 1'b0; en = 1'b0;
        repeat (2) cycle();
        check("rst_drain_clk_en", if0.hwpe_clk_en_o, 4'b1000);
        check("rst_drain_outstanding", if0.outstanding_o, 4'd2);
        do_reset();
        check("rst_flush_outstanding", if0.outstanding_o, 4'd0);
        en = 1'b1; sel = 2'd1;
        repeat (3) cycle();
        check("resume_clk_en", if0.hwpe_clk_en_o, 4'b0010);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            busy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            req  = ($urandom_range(0, 1) == 1);
            gnt  = ($urandom_range(0, 2) != 0);
            rv   = (m_cnt[0] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            cfg  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
